pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a short in-order pipeline: produces per-stage
// load enables and bubble flushes, and sequences memory waits and debug halts.
module pipeline_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DRAIN_CYCLES   = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        imem_ready_in,
  input  logic        dmem_req_in,
  input  logic        dmem_ready_in,
  input  logic        branch_taken_in,
  input  logic        ex_is_load_in,
  input  logic        ex_rf_wr_en_in,
  input  logic [4:0]  ex_rd_addr_in,
  input  logic [4:0]  id_rs1_addr_in,
  input  logic [4:0]  id_rs2_addr_in,
  input  logic        id_rs1_used_in,
  input  logic        id_rs2_used_in,
  input  logic        halt_req_in,
  input  logic        resume_in,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        ex_wb_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic [2:0]  state_o,
  output logic        halted_o,
  output logic        mem_timeout_o,
  output logic [15:0] stall_cycles_o
);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_HALTED   = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);
  localparam logic [2:0] DRAIN_LAST  = 3'(DRAIN_CYCLES - 1);

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic [2:0]  drain_cnt_r;
  logic [15:0] stall_cnt_r;
  logic        halted_r;
  logic        timeout_r;

  logic        mem_stall_s;
  logic        rs1_hit_s;
  logic        rs2_hit_s;
  logic        load_use_s;
  logic        stall_count_en_s;

  assign mem_stall_s = dmem_req_in & ~dmem_ready_in;
  assign rs1_hit_s   = id_rs1_used_in & (id_rs1_addr_in == ex_rd_addr_in);
  assign rs2_hit_s   = id_rs2_used_in & (id_rs2_addr_in == ex_rd_addr_in);
  assign load_use_s  = ex_is_load_in & ex_rf_wr_en_in & (ex_rd_addr_in != 5'd0)
                       & (rs1_hit_s | rs2_hit_s);

  // Stage enables and flushes, decoded from the current state and live hazards
  always_comb begin
    pc_en_o       = 1'b0;
    if_id_en_o    = 1'b0;
    id_ex_en_o    = 1'b0;
    ex_wb_en_o    = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    if (rst_in) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_stall_s) begin
            pc_en_o = 1'b0;
          end else if (branch_taken_in) begin
            {pc_en_o, if_id_en_o, id_ex_en_o, ex_wb_en_o} = 4'b1111;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (load_use_s) begin
            id_ex_en_o    = 1'b1;
            ex_wb_en_o    = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (halt_req_in || !imem_ready_in) begin
            // halt entry looks exactly like a drain cycle: stop fetch, bubble IF/ID
            {if_id_en_o, id_ex_en_o, ex_wb_en_o} = 3'b111;
            if_id_flush_o = 1'b1;
          end else begin
            {pc_en_o, if_id_en_o, id_ex_en_o, ex_wb_en_o} = 4'b1111;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready_in) begin
            {pc_en_o, if_id_en_o, id_ex_en_o, ex_wb_en_o} = 4'b1111;
          end else begin
            pc_en_o = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (mem_stall_s) begin
            pc_en_o = 1'b0;
          end else if (branch_taken_in) begin
            // the redirect target must still be captured while draining
            {pc_en_o, if_id_en_o, id_ex_en_o, ex_wb_en_o} = 4'b1111;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else begin
            {if_id_en_o, id_ex_en_o, ex_wb_en_o} = 3'b111;
            if_id_flush_o = 1'b1;
          end
        end
        default: begin
          pc_en_o = 1'b0;
        end
      endcase
    end
  end

  assign stall_count_en_s = !pc_en_o &&
                            (state_r == ST_RUN || state_r == ST_MEM_WAIT || state_r == ST_DRAIN);

  // Controller state, wait/drain counters and sticky status flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= 8'd0;
      drain_cnt_r <= 3'd0;
      stall_cnt_r <= 16'd0;
      halted_r    <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      if (stall_count_en_s && stall_cnt_r != 16'hFFFF) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      case (state_r)
        ST_RUN: begin
          if (mem_stall_s) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= 8'd1;
          end else if (!branch_taken_in && !load_use_s && halt_req_in) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= 3'd0;
            wait_cnt_r  <= 8'd0;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready_in) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
          end else if (wait_cnt_r == TIMEOUT_VAL) begin
            state_r   <= ST_ERROR;
            timeout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (mem_stall_s) begin
            // drain progress is frozen; the access times out exactly as in MEM_WAIT
            if (wait_cnt_r == TIMEOUT_VAL) begin
              state_r   <= ST_ERROR;
              timeout_r <= 1'b1;
            end else begin
              wait_cnt_r <= wait_cnt_r + 8'd1;
            end
          end else begin
            wait_cnt_r <= 8'd0;
            if (drain_cnt_r == DRAIN_LAST) begin
              state_r     <= ST_HALTED;
              drain_cnt_r <= 3'd0;
              halted_r    <= 1'b1;
            end else begin
              drain_cnt_r <= drain_cnt_r + 3'd1;
            end
          end
        end
        ST_HALTED: begin
          if (resume_in) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end else begin
            state_r <= ST_HALTED;
          end
        end
        ST_ERROR: begin
          state_r   <= ST_ERROR;
          timeout_r <= 1'b1;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  assign state_o        = state_r;
  assign halted_o       = halted_r;
  assign mem_timeout_o  = timeout_r;
  assign stall_cycles_o = stall_cnt_r;

endmodule
